// File: rtl/halflife_counter.sv
// Loadable up/down counter whose value halves every PERIOD cycles after start; outputs registered, 1-cycle latency, no backpressure.
// Define HALFLIFE_COUNT_EN to add the hl_cnt port counting halvings since the last start/load/reset.
module halflife_counter #(
    parameter int N      = 4,
    parameter int PERIOD = 8,
    parameter int SAT    = 0,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          up,
    input  logic          down,
    input  logic          start,
    input  logic [N-1:0]  in,
    output logic [N-1:0]  out,
    output logic          busy,
`ifdef HALFLIFE_COUNT_EN
    output logic [CW-1:0] hl_cnt,
`endif
    output logic          done
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DECAY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  out_q, out_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            presc_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            presc_q <= presc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        presc_d = presc_q;
        if (load) begin
            out_d   = in;
            presc_d = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        presc_d = '0;
                        state_d = (out_q == '0) ? DONE : DECAY;
                    end else if (up && !down) begin
                        if (out_q == {N{1'b1}})
                            out_d = (SAT != 0) ? out_q : '0;
                        else
                            out_d = out_q + N'(1);
                    end else if (down && !up) begin
                        if (out_q == '0)
                            out_d = (SAT != 0) ? out_q : {N{1'b1}};
                        else
                            out_d = out_q - N'(1);
                    end
                end
                DECAY: begin
                    if (presc_q == PLAST) begin
                        out_d   = out_q >> 1;
                        presc_d = '0;
                        // Leave DECAY on the same edge the value reaches zero
                        if (out_q[N-1:1] == '0)
                            state_d = DONE;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                DONE: begin
                    out_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d == DECAY);
        done_d = (state_d == DONE);
    end

`ifdef HALFLIFE_COUNT_EN
    logic [CW-1:0] hl_q, hl_d;
    logic          hl_clr;
    logic          hl_inc;

    assign hl_clr = load || ((state_q == IDLE) && start);
    assign hl_inc = !load && (state_q == DECAY) && (presc_q == PLAST);

    always_comb begin
        hl_d = hl_q;
        if (hl_clr)
            hl_d = '0;
        else if (hl_inc && (hl_q != {CW{1'b1}}))
            hl_d = hl_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            hl_q <= '0;
        else
            hl_q <= hl_d;
    end

    assign hl_cnt = hl_q;
`endif

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_halflife_counter.sv
// Directed bench: two instances (wrapping and saturating) driven by shared inputs.
module tb_halflife_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       start = 1'b0;
    logic [3:0] in = 4'd0;
    logic [3:0] out0, out1;
    logic       busy0, busy1, done0, done1;
`ifdef HALFLIFE_COUNT_EN
    logic [3:0] hl0, hl1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    halflife_counter #(.N(4), .PERIOD(4), .SAT(0), .CW(4)) u_wrap (
        .clk(clk), .rst(rst), .load(load), .up(up), .down(down), .start(start),
        .in(in), .out(out0), .busy(busy0),
`ifdef HALFLIFE_COUNT_EN
        .hl_cnt(hl0),
`endif
        .done(done0)
    );

    halflife_counter #(.N(4), .PERIOD(4), .SAT(1), .CW(4)) u_sat (
        .clk(clk), .rst(rst), .load(load), .up(up), .down(down), .start(start),
        .in(in), .out(out1), .busy(busy1),
`ifdef HALFLIFE_COUNT_EN
        .hl_cnt(hl1),
`endif
        .done(done1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_hl(input string tag, input int exp);
`ifdef HALFLIFE_COUNT_EN
        chk(tag, {28'd0, hl0}, exp);
`else
        if (exp < 0) $display("unused %s", tag);
`endif
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1;
        in = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_out", {28'd0, out0}, 0);
        chk("rst_busy", {31'd0, busy0}, 0);
        chk("rst_done", {31'd0, done0}, 0);
        chk_hl("rst_hl", 0);

        // Decay 12 -> 6 -> 3 -> 1 -> 0
        do_load(4'd12);
        chk("ld12_out", {28'd0, out0}, 12);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("dec_busy", {31'd0, busy0}, 1);
        chk("dec_out0", {28'd0, out0}, 12);
        for (int k = 1; k <= 4; k++) begin
            step();
            step();
            step();
            chk("dec_hold", {28'd0, out0}, 32'(12 >> (k - 1)));
            chk("dec_busy_hold", {31'd0, busy0}, 1);
            step();
            chk("dec_half", {28'd0, out0}, 32'(12 >> k));
        end
        chk("dec_done", {31'd0, done0}, 1);
        chk("dec_busy_end", {31'd0, busy0}, 0);
        chk_hl("dec_hl", 4);
        up = 1'b1;
        start = 1'b1;
        step();
        up = 1'b0;
        start = 1'b0;
        chk("done_ignore_out", {28'd0, out0}, 0);
        chk("done_ignore_done", {31'd0, done0}, 1);

        // Plain up/down, wrap and saturate
        do_load(4'd5);
        up = 1'b1;
        step();
        up = 1'b0;
        chk("up_5", {28'd0, out0}, 6);
        down = 1'b1;
        step();
        step();
        down = 1'b0;
        chk("down_6", {28'd0, out0}, 4);
        do_load(4'd15);
        up = 1'b1;
        step();
        up = 1'b0;
        chk("wrap_up", {28'd0, out0}, 0);
        chk("sat_up", {28'd0, out1}, 15);
        do_load(4'd0);
        down = 1'b1;
        step();
        down = 1'b0;
        chk("wrap_down", {28'd0, out0}, 15);
        chk("sat_down", {28'd0, out1}, 0);
        up = 1'b1;
        down = 1'b1;
        step();
        up = 1'b0;
        down = 1'b0;
        chk("updown_wrap", {28'd0, out0}, 15);
        chk("updown_sat", {28'd0, out1}, 0);

        // Abort decay with load; up/down ignored in DECAY
        do_load(4'd8);
        start = 1'b1;
        step();
        start = 1'b0;
        up = 1'b1;
        step();
        up = 1'b0;
        chk("decay_up_ign", {28'd0, out0}, 8);
        down = 1'b1;
        step();
        down = 1'b0;
        chk("decay_dn_ign", {28'd0, out0}, 8);
        step();
        step();
        step();
        chk("abort_pre_out", {28'd0, out0}, 4);
        chk_hl("abort_pre_hl", 1);
        do_load(4'd9);
        chk("abort_out", {28'd0, out0}, 9);
        chk("abort_busy", {31'd0, busy0}, 0);
        chk("abort_done", {31'd0, done0}, 0);
        chk_hl("abort_hl", 0);
        up = 1'b1;
        step();
        up = 1'b0;
        chk("abort_idle_up", {28'd0, out0}, 10);

        // Reset mid-decay
        do_load(4'd10);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("mid_out", {28'd0, out0}, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_out", {28'd0, out0}, 0);
        chk("mrst_busy", {31'd0, busy0}, 0);
        chk("mrst_done", {31'd0, done0}, 0);
        chk_hl("mrst_hl", 0);

        // Start with zero value
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zs_done", {31'd0, done0}, 1);
        chk("zs_busy", {31'd0, busy0}, 0);
        chk("zs_out", {28'd0, out0}, 0);
        do_load(4'd3);
        chk("zs_ld_done", {31'd0, done0}, 0);
        chk("zs_ld_out", {28'd0, out0}, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
